// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, byte-wide, synchronous-read memory between an
//   instruction-fetch requester (four-byte little-endian bursts) and a
//   data requester (single-byte read or write).
//
//   Data wins arbitration by default. While a fetch is pending, at most
//   MAX_DATA_STREAK data grants are given in a row before the fetch is
//   granted. A grant is decided only in IDLE and always runs to completion;
//   only reset can cut a transaction short.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   if_req, if_addr     fetch request and byte address (held until if_done)
//   if_done, if_instr   fetch completion pulse and assembled instruction
//   d_read, d_write     data read / write requests (held until d_done)
//   d_addr, d_wdata     data address and write byte
//   d_done, d_rdata     data completion pulse and read byte
//   mem_en, mem_we      memory strobe and write enable
//   mem_addr, mem_wdata memory address and write byte
//   mem_rdata           memory read byte (valid the cycle after a read strobe)
//   busy                high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_done,
    output logic [31:0] if_instr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_done,
    output logic [7:0]  d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_ISSUE = 3'd1,
        IF_DRAIN = 3'd2,
        D_READ   = 3'd3,
        D_DRAIN  = 3'd4,
        D_WRITE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic [3:0] streak_q, streak_d;
    logic [7:0] byte0_q, byte0_d;
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] byte2_q, byte2_d;

    logic d_req;
    logic grant_data;
    logic grant_if;

    // Raw (pre-reset-gating) strobes and done pulses.
    logic en_raw, we_raw, if_done_raw, d_done_raw;

    assign d_req = d_read | d_write;

    // Data is preferred unless the fetch has already waited through a full
    // streak of data grants.
    assign grant_data = d_req & ~(if_req & (streak_q == STREAK_MAX));
    assign grant_if   = if_req & ~grant_data;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            streak_q <= '0;
            byte0_q  <= '0;
            byte1_q  <= '0;
            byte2_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            streak_q <= streak_d;
            byte0_q  <= byte0_d;
            byte1_q  <= byte1_d;
            byte2_q  <= byte2_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counters and byte capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        streak_d = streak_q;
        byte0_d  = byte0_q;
        byte1_d  = byte1_q;
        byte2_d  = byte2_q;

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (grant_data) begin
                    // A write takes priority when both data strobes are set.
                    state_d = d_write ? D_WRITE : D_READ;
                    if (if_req) begin
                        if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    state_d  = IF_ISSUE;
                    streak_d = '0;
                end
            end

            IF_ISSUE: begin
                // mem_rdata in beat N is the byte strobed during beat N-1.
                unique case (beat_q)
                    2'd1:    byte0_d = mem_rdata;
                    2'd2:    byte1_d = mem_rdata;
                    2'd3:    byte2_d = mem_rdata;
                    default: ;
                endcase
                if (beat_q == 2'd3) begin
                    state_d = IF_DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end

            IF_DRAIN: state_d = IDLE;
            D_READ:   state_d = D_DRAIN;
            D_DRAIN:  state_d = IDLE;
            D_WRITE:  state_d = IDLE;

            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        en_raw      = 1'b0;
        we_raw      = 1'b0;
        if_done_raw = 1'b0;
        d_done_raw  = 1'b0;
        mem_addr    = d_addr;

        unique case (state_q)
            IF_ISSUE: begin
                en_raw   = 1'b1;
                mem_addr = if_addr + {6'd0, beat_q};
            end
            IF_DRAIN: if_done_raw = 1'b1;
            D_READ:   en_raw = 1'b1;
            D_DRAIN:  d_done_raw = 1'b1;
            D_WRITE: begin
                en_raw     = 1'b1;
                we_raw     = 1'b1;
                d_done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses all strobes in the same cycle, so a burst cut by
    // reset never touches memory again nor reports completion.
    assign mem_en  = rst_n & en_raw;
    assign mem_we  = rst_n & we_raw;
    assign if_done = rst_n & if_done_raw;
    assign d_done  = rst_n & d_done_raw;

    assign mem_wdata = d_wdata;
    assign if_instr  = {mem_rdata, byte2_q, byte1_q, byte0_q};
    assign d_rdata   = mem_rdata;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with a behavioural synchronous-read
//   memory. Expected instructions, read bytes and grant order are queued
//   when a request is driven and compared when the matching done appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_done;
    logic [31:0] if_instr;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic        d_done;
    logic [7:0]  d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic [31:0] instr_q [$];
    logic [7:0]  rdata_q [$];
    logic [7:0]  grant_q [$];

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_instr  (if_instr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Single-port memory, synchronous read.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            else                 mem_rdata <= mem[mem_addr];
        end
    end

    // Called at a negedge with the arbiter idle and no other request active.
    task automatic run_fetch(input logic [7:0] a);
        logic [7:0]  ea;
        logic [31:0] exp;
        if_req  = 1'b1;
        if_addr = a;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            ea = a + 8'(b);
            checks++;
            if ({mem_en, mem_we, mem_addr, if_done, busy} !== {1'b1, 1'b0, ea, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL fetch_beat%0d: en/we/addr/if_done/busy got %b/%b/%h/%b/%b expected 1/0/%h/0/1",
                         b, mem_en, mem_we, mem_addr, if_done, busy, ea);
            end
        end
        @(negedge clk);
        checks++;
        if ({if_done, mem_en, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_done: if_done/en/we got %b/%b/%b expected 1/0/0", if_done, mem_en, mem_we);
        end
        exp = (instr_q.size() > 0) ? instr_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (if_instr !== exp) begin
            errors++;
            $display("FAIL fetch_instr: if_instr got %h expected %h", if_instr, exp);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, if_done} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_idle: busy/if_done got %b/%b expected 0/0", busy, if_done);
        end
    endtask

    task automatic run_write(input logic [7:0] a, input logic [7:0] d, input logic also_read);
        d_write = 1'b1;
        d_read  = also_read;
        d_addr  = a;
        d_wdata = d;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, d_done, if_done} !== {1'b1, 1'b1, a, d, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_cycle: en/we/addr/wdata/d_done/if_done got %b/%b/%h/%h/%b/%b expected 1/1/%h/%h/1/0",
                     mem_en, mem_we, mem_addr, mem_wdata, d_done, if_done, a, d);
        end
        d_write = 1'b0;
        d_read  = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, d_done, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL write_idle: busy/d_done/en got %b/%b/%b expected 0/0/0", busy, d_done, mem_en);
        end
    endtask

    task automatic run_read(input logic [7:0] a);
        logic [7:0] exp;
        d_read = 1'b1;
        d_addr = a;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, d_done} !== {1'b1, 1'b0, a, 1'b0}) begin
            errors++;
            $display("FAIL read_issue: en/we/addr/d_done got %b/%b/%h/%b expected 1/0/%h/0",
                     mem_en, mem_we, mem_addr, d_done, a);
        end
        @(negedge clk);
        checks++;
        if ({d_done, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL read_done: d_done/en got %b/%b expected 1/0", d_done, mem_en);
        end
        exp = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'hXX;
        checks++;
        if (d_rdata !== exp) begin
            errors++;
            $display("FAIL read_data: d_rdata got %h expected %h", d_rdata, exp);
        end
        d_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, d_done} !== 2'b00) begin
            errors++;
            $display("FAIL read_idle: busy/d_done got %b/%b expected 0/0", busy, d_done);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        if_req = 1'b1;
        d_read = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_en, mem_we, if_done, d_done} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: busy/en/we/if_done/d_done got %b/%b/%b/%b/%b expected 0/0/0/0/0",
                     busy, mem_en, mem_we, if_done, d_done);
        end
        checks++;
        if (if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: if_instr got %h expected 00000000", if_instr);
        end
        if_req = 1'b0;
        d_read = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, mem_en} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy/en got %b/%b expected 0/0", busy, mem_en);
        end
    endtask

    task automatic test_fetch();
        instr_q.push_back(32'h0050_0013);
        run_fetch(8'h10);
    endtask

    task automatic test_wrap();
        instr_q.push_back(32'hD4C3_B2A1);
        run_fetch(8'hFE);
    endtask

    task automatic test_write_read();
        run_write(8'h20, 8'h5A, 1'b0);
        rdata_q.push_back(8'h5A);
        run_read(8'h20);
    endtask

    task automatic test_rw_simul();
        run_write(8'h30, 8'h77, 1'b1);
        rdata_q.push_back(8'h77);
        run_read(8'h30);
    endtask

    task automatic test_reset_midburst();
        if_req  = 1'b1;
        if_addr = 8'h10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL rstmid_beat1: en/addr got %b/%h expected 1/11", mem_en, mem_addr);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_done} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_gate: en/we/if_done got %b/%b/%b expected 0/0/0", mem_en, mem_we, if_done);
        end
        @(negedge clk);
        checks++;
        if ({busy, if_done, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_idle: busy/if_done/en got %b/%b/%b expected 0/0/0", busy, if_done, mem_en);
        end
        rst_n = 1'b1;
        instr_q.push_back(32'h0050_0013);
        run_fetch(8'h10);
    endtask

    task automatic test_fairness();
        logic [7:0] got;
        logic [7:0] exp;
        int         budget;
        string      order;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        order = "DDDDIDDDDI";
        for (int i = 0; i < order.len(); i++) grant_q.push_back(order[i]);
        d_read  = 1'b1;
        d_addr  = 8'h20;
        if_req  = 1'b1;
        if_addr = 8'h10;
        budget  = 120;
        while (grant_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (d_done === 1'b1 || if_done === 1'b1) begin
                got = (d_done === 1'b1 && if_done === 1'b1) ? "B" : (d_done === 1'b1 ? "D" : "I");
                exp = grant_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL fair_grant%0d: grant got %c expected %c", 10 - grant_q.size(), got, exp);
                end
                if (grant_q.size() == 0) begin
                    d_read = 1'b0;
                    if_req = 1'b0;
                end
            end
        end
        d_read = 1'b0;
        if_req = 1'b0;
        checks++;
        if (grant_q.size() != 0) begin
            errors++;
            $display("FAIL fair_timeout: grants outstanding got %0d expected 0", grant_q.size());
            grant_q.delete();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_idle: busy got %b expected 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h13;
        mem[8'h11] = 8'h00;
        mem[8'h12] = 8'h50;
        mem[8'h13] = 8'h00;
        mem[8'hFE] = 8'hA1;
        mem[8'hFF] = 8'hB2;
        mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'hD4;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_wrap();
        test_write_read();
        test_rw_simul();
        test_reset_midburst();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4: the maximum number of consecutive data grants while a fetch is pending (range 1..15).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  8  byte address of the 32-bit instruction.
- if_done  out  1  one-cycle pulse; if_instr is valid in that cycle.
- if_instr  out  32  fetched instruction, little-endian.
- d_read  in  1  data-byte read request; held with d_addr until d_done.
- d_write  in  1  data-byte write request; held with d_addr and d_wdata until d_done.
- d_addr  in  8  data address.
- d_wdata  in  8  write data.
- d_done  out  1  one-cycle pulse marking data-access completion.
- d_rdata  out  8  read data; valid while d_done is high after a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  synchronous-read data; valid in the cycle after a read strobe.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL share one single-port 8-bit memory between the instruction fetch (IF) port and the data (MEM-stage) port, with FSM states IDLE, IF_ISSUE, IF_DRAIN, D_READ, D_DRAIN and D_WRITE.
REQ-004 SHALL drive mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, if_instr and d_rdata combinationally from the state, the 2-bit beat counter, the latched byte registers and the held requester inputs.
REQ-005 SHALL make the arbitration decision only in IDLE and SHALL never preempt a transaction in progress.
REQ-006 SHALL arbitrate in IDLE as follows:
- Data request only: data is granted.
- if_req only: IF is granted.
- Both pending: data is granted unless streak == MAX_DATA_STREAK, in which case IF is granted.
REQ-007 SHALL maintain a 4-bit streak counter with these updates:
- +1 (saturating at MAX_DATA_STREAK) on a data grant while if_req is high.
- Cleared on a data grant while if_req is low.
- Cleared on every IF grant.
REQ-008 SHALL run an IF grant decided in IDLE at cycle T as follows:
- Cycles T+1..T+4: IF_ISSUE, beat 0..3, with mem_en=1, mem_we=0, mem_addr=if_addr+beat (mod 256, so it wraps).
- Cycle T+5: IF_DRAIN.
- Cycle T+6: IDLE.
REQ-009 SHALL capture mem_rdata into instruction byte beat-1 during IF_ISSUE beats 1..3.
REQ-010 SHALL, in IF_DRAIN, assert if_done=1 with if_instr={mem_rdata, byte2, byte1, byte0}.
REQ-011 SHALL run a data read granted at T as follows:
- Cycle T+1: D_READ, with mem_en=1, mem_we=0, mem_addr=d_addr.
- Cycle T+2: D_DRAIN, with d_done=1 and d_rdata=mem_rdata.
- Cycle T+3: IDLE.
REQ-012 SHALL run a data write granted at T as follows:
- Cycle T+1: D_WRITE, with mem_en=1, mem_we=1, mem_addr=d_addr, mem_wdata=d_wdata and d_done=1.
- Cycle T+2: IDLE.
REQ-013 SHALL perform only the write when d_read and d_write are both high, producing a single d_done.
REQ-014 SHALL drive mem_en=0, mem_we=0, if_done=0 and d_done=0 in IDLE and in each drain state except for the signals explicitly listed above.
REQ-015 SHALL complete a granted transaction and pulse its done even if the request drops mid-transaction.
REQ-016 SHALL hold if_instr at the last captured bytes and d_rdata at mem_rdata when the corresponding done is low; neither value has meaning in that case.
REQ-017 SHALL keep requesters waiting with no output activity toward them until their grant; waiting requesters stall their pipeline on ~done.

Reset
REQ-018 SHALL, on a clock edge with rst_n=0, enter IDLE and clear the beat counter, the streak counter and the instruction byte registers to 0.
REQ-019 SHALL force mem_en, mem_we, if_done and d_done to 0 combinationally in any cycle where rst_n=0, including a reset that lands mid-burst.
REQ-020 SHALL complete no transaction interrupted by reset and SHALL emit no done pulse for it; after reset the requester re-arbitrates from IDLE.

Verification
REQ-021 SHALL pass a fetch scenario: memory[0x10..0x13]=13,00,50,00; if_req with if_addr=0x10 sampled at T -> mem_addr 10,11,12,13 at T+1..T+4, then if_done=1 with if_instr=0x00500013 at T+5, then busy=0 at T+6.
REQ-022 SHALL pass an address-wrap scenario: if_addr=0xFE -> mem_addr FE,FF,00,01 in successive cycles, with the instruction assembled in that byte order.
REQ-023 SHALL pass a write-then-read scenario: d_write with d_addr=0x20, d_wdata=0x5A -> mem_en=mem_we=1 and d_done at T+1; then d_read at 0x20 -> d_done with d_rdata=0x5A two cycles after its grant.
REQ-024 SHALL pass a fairness scenario: d_read and if_req held high continuously with MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-025 SHALL pass a reset-at-beat-2 scenario: rst_n=0 during an IF burst at beat 2 -> mem_en=0 in that cycle, IDLE on the next edge, no if_done pulse; fetch restarts at beat 0 once rst_n rises.
REQ-026 SHALL pass a simultaneous read-and-write scenario: d_read=d_write=1 at 0x30 with d_wdata=0x77 -> one write cycle and one d_done; a later read of 0x30 returns 0x77.
